// File: rtl/viterbi_acs_sched_if.sv
// rtl/viterbi_acs_sched_if.sv - symbol, ACS bank, survivor and traceback signals of the ACS scheduler
// With ACS_SCHED_STALL_CNT_EN defined the interface also carries stall_cnt.
interface viterbi_acs_sched_if #(
  parameter int GRP_W  = 3,
  parameter int ADDR_W = 5
);
  logic              sym_valid;
  logic              sym_ready;
  logic [1:0]        sym_in;
  logic              sym_last;
  logic [1:0]        bmc_rx_pair;
  logic              acs_en;
  logic [GRP_W-1:0]  acs_grp;
  logic              pm_bank_sel;
  logic              norm_en;
  logic              acs_msb_any;
  logic              surv_wr_en;
  logic [ADDR_W-1:0] surv_wr_addr;
  logic              tb_start;
  logic              tb_done;
  logic              frame_done;
`ifdef ACS_SCHED_STALL_CNT_EN
  logic [15:0]       stall_cnt;

  modport sched (
    input  sym_valid, sym_in, sym_last, acs_msb_any, tb_done,
    output sym_ready, bmc_rx_pair, acs_en, acs_grp, pm_bank_sel, norm_en,
           surv_wr_en, surv_wr_addr, tb_start, frame_done, stall_cnt
  );

  modport env (
    output sym_valid, sym_in, sym_last, acs_msb_any, tb_done,
    input  sym_ready, bmc_rx_pair, acs_en, acs_grp, pm_bank_sel, norm_en,
           surv_wr_en, surv_wr_addr, tb_start, frame_done, stall_cnt
  );
`else
  modport sched (
    input  sym_valid, sym_in, sym_last, acs_msb_any, tb_done,
    output sym_ready, bmc_rx_pair, acs_en, acs_grp, pm_bank_sel, norm_en,
           surv_wr_en, surv_wr_addr, tb_start, frame_done
  );

  modport env (
    output sym_valid, sym_in, sym_last, acs_msb_any, tb_done,
    input  sym_ready, bmc_rx_pair, acs_en, acs_grp, pm_bank_sel, norm_en,
           surv_wr_en, surv_wr_addr, tb_start, frame_done
  );
`endif
endinterface

// File: rtl/viterbi_acs_sched.sv
// rtl/viterbi_acs_sched.sv - steps the shared ACS bank through all state groups once per trellis symbol
// Optional macro ACS_SCHED_STALL_CNT_EN adds a saturating stall_cnt output.
module viterbi_acs_sched #(
  parameter int NUM_STATES = 64,
  parameter int NUM_ACS    = 8,
  parameter int TB_DEPTH   = 32
) (
  input logic                clk,
  input logic                rst_n,
  viterbi_acs_sched_if.sched bus
);
  localparam int G  = NUM_STATES / NUM_ACS;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int AW = $clog2(TB_DEPTH);
  localparam logic [GW-1:0] GRP_LAST  = GW'(G - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(TB_DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, TBK = 2'd2} state_t;

  state_t        state, state_n;
  logic [GW-1:0] grp;
  logic [AW-1:0] addr;
  logic [1:0]    rx_pair;
  logic          rdy, last, norm_pending, norm_q, msb_acc, bank;
  logic          tb_start_q, frame_done_q;
  logic          run_en, accept, step_end, wrap, tb_ack;

  assign accept   = bus.sym_valid & rdy;
  assign step_end = (state == RUN) && (grp == GRP_LAST);
  assign wrap     = (addr == ADDR_LAST);
  // The cycle carrying tb_start cannot also acknowledge the traceback.
  assign tb_ack   = (state == TBK) && bus.tb_done && !tb_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    run_en  = 1'b0;
    case (state)
      IDLE: if (accept) state_n = RUN;
      RUN: begin
        run_en = 1'b1;
        if (grp == GRP_LAST) state_n = (wrap || last) ? TBK : IDLE;
      end
      TBK:     if (tb_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy          <= 1'b0;
      rx_pair      <= 2'b00;
      last         <= 1'b0;
      grp          <= '0;
      addr         <= '0;
      bank         <= 1'b0;
      norm_pending <= 1'b0;
      norm_q       <= 1'b0;
      msb_acc      <= 1'b0;
      tb_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      rdy          <= (state_n == IDLE);
      tb_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (accept) begin
        rx_pair <= bus.sym_in;
        last    <= bus.sym_last;
        grp     <= '0;
        norm_q  <= norm_pending;
      end
      if (state == RUN) begin
        if (step_end) begin
          grp          <= '0;
          bank         <= ~bank;
          norm_pending <= msb_acc | bus.acs_msb_any;
          msb_acc      <= 1'b0;
          norm_q       <= 1'b0;
          addr         <= addr + AW'(1);
          tb_start_q   <= wrap | last;
        end else begin
          grp     <= grp + GW'(1);
          msb_acc <= msb_acc | bus.acs_msb_any;
        end
      end
      // End of frame: next frame starts from bank 0, column 0, no pending normalization.
      if (tb_ack && last) begin
        frame_done_q <= 1'b1;
        bank         <= 1'b0;
        addr         <= '0;
        norm_pending <= 1'b0;
        last         <= 1'b0;
      end
    end
  end

  assign bus.sym_ready    = rdy;
  assign bus.bmc_rx_pair  = rx_pair;
  assign bus.acs_en       = run_en;
  assign bus.acs_grp      = grp;
  assign bus.pm_bank_sel  = bank;
  assign bus.norm_en      = norm_q;
  assign bus.surv_wr_en   = run_en;
  assign bus.surv_wr_addr = addr;
  assign bus.tb_start     = tb_start_q;
  assign bus.frame_done   = frame_done_q;

`ifdef ACS_SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else if (tb_ack && last) begin
      stall_q <= 16'h0000;
    end else if (bus.sym_valid && !rdy && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end
  end

  assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_viterbi_acs_sched.sv
// tb/tb_viterbi_acs_sched.sv - randomized self-checking bench for viterbi_acs_sched against a step-level model
module tb_viterbi_acs_sched;
  localparam int NS = 64;
  localparam int NA = 8;
  localparam int TD = 32;
  localparam int G  = NS / NA;
  localparam int GW = $clog2(G);
  localparam int AW = $clog2(TD);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = 0;

  // Step-level reference: bank parity, survivor column, pending normalization.
  bit m_bank;
  int m_addr;
  bit m_norm;

  viterbi_acs_sched_if #(.GRP_W(GW), .ADDR_W(AW)) bus ();

  viterbi_acs_sched #(.NUM_STATES(NS), .NUM_ACS(NA), .TB_DEPTH(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.sched)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_sym(input logic [1:0] s, input bit l, input logic [G-1:0] mask,
                          input bit hold, input int exp_gap, output bit tb);
    int n = 0;
    logic [GW+AW+6:0] obs, exp;
    logic [AW+6:0] pobs, pexp;
    bus.sym_valid = 1'b1;
    bus.sym_in    = s;
    bus.sym_last  = l;
    while (bus.sym_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL accept_timeout sym_ready=%b required=1", bus.sym_ready);
    end
    if (exp_gap != 0) begin
      total++;
      if (cyc - last_acc != exp_gap) begin
        bad++;
        $display("FAIL accept_spacing got=%0d want=%0d", cyc - last_acc, exp_gap);
      end
    end
    last_acc = cyc;
    @(negedge clk);
    if (!hold) bus.sym_valid = 1'b0;
    for (int g = 0; g < G; g++) begin
      bus.sym_in      = 2'($urandom);
      bus.sym_last    = 1'($urandom);
      bus.acs_msb_any = mask[g];
      obs = {bus.acs_en, bus.surv_wr_en, bus.sym_ready, bus.acs_grp, bus.bmc_rx_pair,
             bus.norm_en, bus.pm_bank_sel, bus.surv_wr_addr};
      exp = {1'b1, 1'b1, 1'b0, GW'(g), s, m_norm, m_bank, AW'(m_addr)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL step_cycle g=%0d got=%h want=%h", g, obs, exp);
      end
      @(negedge clk);
    end
    bus.acs_msb_any = 1'b0;
    m_bank = !m_bank;
    m_norm = |mask;
    m_addr = (m_addr + 1) % TD;
    tb     = (m_addr == 0) || l;
    pobs = {bus.tb_start, bus.sym_ready, bus.acs_en, bus.frame_done, bus.norm_en,
            bus.pm_bank_sel, bus.surv_wr_addr};
    pexp = {tb, !tb, 1'b0, 1'b0, 1'b0, m_bank, AW'(m_addr)};
    total++;
    if (pobs !== pexp) begin
      bad++;
      $display("FAIL step_end got=%h want=%h", pobs, pexp);
    end
  endtask

  task automatic do_traceback(input bit l, input bit early, input int wait_n, input bit keep);
    logic [AW+2:0] obs, exp;
    bus.tb_done = early;
    @(negedge clk);
    bus.tb_done = 1'b0;
    for (int i = 0; i < wait_n; i++) begin
      total++;
      if ({bus.sym_ready, bus.tb_start, bus.frame_done, bus.acs_en} !== 4'b0000) begin
        bad++;
        $display("FAIL tbk_wait i=%0d got=%b want=0000", i,
                 {bus.sym_ready, bus.tb_start, bus.frame_done, bus.acs_en});
      end
      @(negedge clk);
    end
    bus.tb_done = 1'b1;
    @(negedge clk);
    bus.tb_done = 1'b0;
    if (!keep || l) bus.sym_valid = 1'b0;
    if (l) begin
      m_bank = 1'b0;
      m_addr = 0;
      m_norm = 1'b0;
    end
    obs = {bus.frame_done, bus.sym_ready, bus.pm_bank_sel, bus.surv_wr_addr};
    exp = {l, 1'b1, m_bank, AW'(m_addr)};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL tb_release got=%h want=%h", obs, exp);
    end
`ifdef ACS_SCHED_STALL_CNT_EN
    if (l) begin
      total++;
      if (bus.stall_cnt !== 16'h0000) begin
        bad++;
        $display("FAIL stall_clear got=%0d want=0", bus.stall_cnt);
      end
    end
`endif
    if (l) begin
      @(negedge clk);
      total++;
      if ({bus.frame_done, bus.sym_ready} !== 2'b01) begin
        bad++;
        $display("FAIL frame_done_pulse got=%b want=01", {bus.frame_done, bus.sym_ready});
      end
    end
  endtask

  task automatic test_reset();
    logic [GW+AW+9:0] v;
    bus.sym_valid = 1'b0; bus.sym_in = 2'b00; bus.sym_last = 1'b0;
    bus.acs_msb_any = 1'b0; bus.tb_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    v = {bus.sym_ready, bus.bmc_rx_pair, bus.acs_en, bus.acs_grp, bus.pm_bank_sel, bus.norm_en,
         bus.surv_wr_en, bus.surv_wr_addr, bus.tb_start, bus.frame_done};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", v);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.sym_ready, bus.acs_en} !== 2'b10) begin
      bad++;
      $display("FAIL reset_release got=%b want=10", {bus.sym_ready, bus.acs_en});
    end
    m_bank = 1'b0; m_addr = 0; m_norm = 1'b0;
  endtask

  task automatic test_single();
    bit tb;
    send_sym(2'b10, 1'b0, '0, 1'b0, 0, tb);
    bus.tb_done = 1'b1;
    @(negedge clk);
    bus.tb_done = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.sym_ready, bus.frame_done, bus.tb_start, bus.pm_bank_sel, bus.surv_wr_addr}
        !== {1'b1, 1'b0, 1'b0, 1'b1, AW'(1)}) begin
      bad++;
      $display("FAIL idle_tb_done_ignored got=%h want=%h",
               {bus.sym_ready, bus.frame_done, bus.tb_start, bus.pm_bank_sel, bus.surv_wr_addr},
               {1'b1, 1'b0, 1'b0, 1'b1, AW'(1)});
    end
  endtask

  task automatic test_reset_mid_run();
    logic [GW+AW+9:0] v;
    bit tb;
    bus.sym_valid = 1'b1; bus.sym_in = 2'b01; bus.sym_last = 1'b0;
    @(negedge clk);
    bus.sym_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.acs_grp !== GW'(3)) begin
      bad++;
      $display("FAIL mid_run_grp got=%0d want=3", bus.acs_grp);
    end
    rst_n = 1'b0;
    #1;
    v = {bus.sym_ready, bus.bmc_rx_pair, bus.acs_en, bus.acs_grp, bus.pm_bank_sel, bus.norm_en,
         bus.surv_wr_en, bus.surv_wr_addr, bus.tb_start, bus.frame_done};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_bank = 1'b0; m_addr = 0; m_norm = 1'b0;
    @(negedge clk);
    send_sym(2'b11, 1'b0, '0, 1'b0, 0, tb);
  endtask

  task automatic test_norm();
    bit tb;
    logic [G-1:0] mk;
    mk = '0;
    mk[$urandom_range(0, G - 1)] = 1'b1;
    send_sym(2'($urandom), 1'b0, mk, 1'b0, 0, tb);
    send_sym(2'($urandom), 1'b0, '0, 1'b0, 0, tb);
    send_sym(2'($urandom), 1'b0, '0, 1'b0, 0, tb);
  endtask

  task automatic test_frame();
    bit tb;
    for (int i = 0; i < 5; i++) begin
      send_sym(2'($urandom), (i == 4), '0, 1'b0, 0, tb);
      if (tb) do_traceback((i == 4), 1'b1, 2, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    bit tb;
    for (int i = 0; i < TD; i++) begin
      send_sym(2'($urandom), 1'b0, G'($urandom_range(0, 3) == 0 ? $urandom : 0), 1'b1,
               (i == 0) ? 0 : G + 1, tb);
      if (tb) begin
        total++;
        if (i != TD - 1) begin
          bad++;
          $display("FAIL early_wrap step=%0d want=%0d", i, TD - 1);
        end
        do_traceback(1'b0, 1'b1, 5, 1'b0);
      end
    end
  endtask

  task automatic test_random();
    bit tb;
    int len;
    bit l, hold;
    logic [G-1:0] mk;
    for (int f = 0; f < 3; f++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        l    = (i == len - 1);
        hold = ($urandom_range(0, 1) == 1) && !l;
        mk   = '0;
        if ($urandom_range(0, 3) == 0) mk[$urandom_range(0, G - 1)] = 1'b1;
        send_sym(2'($urandom), l, mk, hold, 0, tb);
        if (tb) do_traceback(l, 1'($urandom), $urandom_range(1, 6), hold);
      end
    end
  endtask

`ifdef ACS_SCHED_STALL_CNT_EN
  task automatic test_stall();
    bit tb;
    total++;
    if (bus.stall_cnt !== 16'h0000) begin
      bad++;
      $display("FAIL stall_start got=%0d want=0", bus.stall_cnt);
    end
    send_sym(2'b01, 1'b1, '0, 1'b1, 0, tb);
    total++;
    if (bus.stall_cnt !== 16'd8) begin
      bad++;
      $display("FAIL stall_count got=%0d want=8", bus.stall_cnt);
    end
    do_traceback(1'b1, 1'b0, 3, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_reset_mid_run();
    test_norm();
    test_frame();
    test_back_to_back();
    test_random();
`ifdef ACS_SCHED_STALL_CNT_EN
    test_stall();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
